unified_buffer_mc: RTL and testbench

Parametrised multi-channel unified buffer that succeeds the fixed 2-accumulator / 64-word version. It collects result groups from NUM_CH accumulator channels into a single DATA_W-wide memory using an auto-incrementing write pointer. The write base is loadable and the pointer can optionally wrap. A host preload port and a burst read engine stream activations to the input setup block.

---
 rtl/unified_buffer_mc.sv | 163 ++++++++++++++++
 tb/tb_unified_buffer_mc.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_buffer_mc.sv
// Multi-channel unified buffer: accumulator groups land at an auto-incrementing pointer, host preloads single words.
// Read beats leave 2 cycles after rd_start, one beat per 2 cycles; rd_valid holds data while rd_ready is low.
module unified_buffer_mc #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 64,
  parameter int NUM_CH       = 2,
  parameter int WORDS_PER_CH = 2,
  parameter int RD_LANES     = 2,
  parameter int WRAP_EN      = 0,
  parameter int ADDR_W       = $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CH-1:0]                    wr_valid,
  input  logic [NUM_CH*WORDS_PER_CH*DATA_W-1:0] wr_data,
  output logic                                 wr_ready,
  input  logic                                 wr_base_load,
  input  logic [ADDR_W-1:0]                    wr_base_addr,
  output logic [ADDR_W-1:0]                    wr_ptr,
  output logic                                 full,
  output logic                                 overflow,
  input  logic                                 init_we,
  input  logic [ADDR_W-1:0]                    init_addr,
  input  logic [DATA_W-1:0]                    init_data,
  input  logic                                 rd_start,
  input  logic [ADDR_W-1:0]                    rd_addr,
  input  logic [ADDR_W:0]                      rd_len,
  input  logic                                 rd_ready,
  output logic                                 rd_valid,
  output logic [RD_LANES*DATA_W-1:0]           rd_data,
  output logic                                 rd_busy,
  output logic                                 rd_done
);

  localparam int G   = NUM_CH * WORDS_PER_CH;
  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0]   G_W     = AW1'(G);
  localparam logic [ADDR_W:0]   DEPTH_W = AW1'(DEPTH);
  localparam logic [ADDR_W:0]   LANES_W = AW1'(RD_LANES);
  localparam logic [ADDR_W-1:0] G_A     = ADDR_W'(G);
  localparam logic [ADDR_W-1:0] LANES_A = ADDR_W'(RD_LANES);

  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_BEAT} rd_state_e;

  logic [DATA_W-1:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic                       overflow_q, overflow_d;
  logic                       grp_vld, commit, drop;

  rd_state_e                  state_q, state_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [ADDR_W:0]            rem_q, rem_d;
  logic [RD_LANES*DATA_W-1:0] data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       done_q, done_d;

  // Space check is one bit wider so wr_ptr + G cannot alias below DEPTH.
  always_comb begin
    full       = (WRAP_EN == 0) && (({1'b0, wr_ptr_q} + G_W) > DEPTH_W);
    grp_vld    = &wr_valid;
    wr_ready   = !init_we && !wr_base_load && ((WRAP_EN != 0) || !full);
    commit     = grp_vld && wr_ready;
    drop       = grp_vld && full && !init_we && !wr_base_load;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    if (wr_base_load) begin
      wr_ptr_d   = wr_base_addr;
      overflow_d = 1'b0;
    end else if (commit) begin
      wr_ptr_d = wr_ptr_q + G_A;
    end else if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // commit already excludes init_we, so the two write sources never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (init_we) begin
      mem_q[init_addr] <= init_data;
    end else if (commit) begin
      for (int k = 0; k < G; k++)
        mem_q[wr_ptr_q + ADDR_W'(k)] <= wr_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (rd_start && (rd_len != '0)) begin
          addr_d  = rd_addr;
          rem_d   = rd_len;
          state_d = RD_FETCH;
        end
      end
      RD_FETCH: begin
        for (int l = 0; l < RD_LANES; l++) begin
          if (AW1'(l) < rem_q) data_d[l*DATA_W +: DATA_W] = mem_q[addr_q + ADDR_W'(l)];
          else                 data_d[l*DATA_W +: DATA_W] = '0;
        end
        valid_d = 1'b1;
        state_d = RD_BEAT;
      end
      RD_BEAT: begin
        if (rd_ready) begin
          addr_d  = addr_q + LANES_A;
          rem_d   = (rem_q > LANES_W) ? (rem_q - LANES_W) : '0;
          valid_d = 1'b0;
          if (rem_d == '0) begin
            done_d  = 1'b1;
            state_d = RD_IDLE;
          end else begin
            state_d = RD_FETCH;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RD_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign wr_ptr   = wr_ptr_q;
  assign overflow = overflow_q;
  assign rd_valid = valid_q;
  assign rd_data  = data_q;
  assign rd_busy  = (state_q != RD_IDLE);
  assign rd_done  = done_q;

endmodule

// File: tb/tb_unified_buffer_mc.sv
// Bench for unified_buffer_mc: saturating (WRAP_EN=0) and wrapping (WRAP_EN=1) instances share stimulus
// and are checked against an array/queue reference model of memory, pointer and read bursts.
module tb_unified_buffer_mc;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   wr_valid;
  logic [127:0] wr_data;
  logic         wr_base_load;
  logic [5:0]   wr_base_addr;
  logic         init_we;
  logic [5:0]   init_addr;
  logic [31:0]  init_data;
  logic         rd_start;
  logic [5:0]   rd_addr;
  logic [6:0]   rd_len;
  logic         rd_ready;

  logic [1:0]   wr_ready_v, full_v, overflow_v, rd_valid_v, rd_busy_v, rd_done_v;
  logic [5:0]   wr_ptr_v [2];
  logic [63:0]  rd_data_v [2];

  logic [31:0]  mm [2][64];
  int           mptr [2];
  bit           movf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  unified_buffer_mc #(.WRAP_EN(0)) dut_sat (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready_v[0]),
    .wr_base_load(wr_base_load), .wr_base_addr(wr_base_addr), .wr_ptr(wr_ptr_v[0]),
    .full(full_v[0]), .overflow(overflow_v[0]), .init_we(init_we), .init_addr(init_addr),
    .init_data(init_data), .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_ready(rd_ready), .rd_valid(rd_valid_v[0]), .rd_data(rd_data_v[0]),
    .rd_busy(rd_busy_v[0]), .rd_done(rd_done_v[0]));

  unified_buffer_mc #(.WRAP_EN(1)) dut_wrap (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready_v[1]),
    .wr_base_load(wr_base_load), .wr_base_addr(wr_base_addr), .wr_ptr(wr_ptr_v[1]),
    .full(full_v[1]), .overflow(overflow_v[1]), .init_we(init_we), .init_addr(init_addr),
    .init_data(init_data), .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_ready(rd_ready), .rd_valid(rd_valid_v[1]), .rd_data(rd_data_v[1]),
    .rd_busy(rd_busy_v[1]), .rd_done(rd_done_v[1]));

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 64; i++) mm[w][i] = 32'd0;
      mptr[w] = 0;
    end
    movf = 1'b0;
  endtask

  task automatic idle_inputs();
    wr_valid = 2'b00; wr_data = '0; wr_base_load = 1'b0; wr_base_addr = '0;
    init_we = 1'b0; init_addr = '0; init_data = '0;
    rd_start = 1'b0; rd_addr = '0; rd_len = '0; rd_ready = 1'b0;
  endtask

  // One clock: check write-side outputs against the model, clock, then apply the model rules.
  task automatic step();
    bit fl [2];
    bit rdy [2];
    bit allv;
    allv = &wr_valid;
    #1;
    for (int w = 0; w < 2; w++) begin
      fl[w]  = (w == 0) && (mptr[w] + 4 > 64);
      rdy[w] = !init_we && !wr_base_load && !fl[w];
      check_eq($sformatf("full%0d", w), 64'(full_v[w]), 64'(fl[w]));
      check_eq($sformatf("wr_ready%0d", w), 64'(wr_ready_v[w]), 64'(rdy[w]));
      check_eq($sformatf("wr_ptr%0d", w), 64'(wr_ptr_v[w]), 64'(mptr[w]));
    end
    check_eq("overflow0", 64'(overflow_v[0]), 64'(movf));
    check_eq("overflow1", 64'(overflow_v[1]), 64'd0);
    @(posedge clk);
    for (int w = 0; w < 2; w++) begin
      if (init_we) mm[w][init_addr] = init_data;
      if (wr_base_load) begin
        mptr[w] = int'(wr_base_addr);
        if (w == 0) movf = 1'b0;
      end else if (allv && rdy[w]) begin
        for (int k = 0; k < 4; k++) mm[w][(mptr[w] + k) % 64] = wr_data[k*32 +: 32];
        mptr[w] = (mptr[w] + 4) % 64;
      end else if (w == 0 && allv && fl[w] && !init_we) begin
        movf = 1'b1;
      end
    end
    #1;
  endtask

  function automatic logic [63:0] beat_val(input int w, input int a, input int n, input int b);
    logic [63:0] r;
    r = '0;
    for (int l = 0; l < 2; l++)
      if (b*2 + l < n) r[l*32 +: 32] = mm[w][(a + b*2 + l) % 64];
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    for (int w = 0; w < 2; w++) begin
      check_eq({tag, "_rd_valid"}, 64'(rd_valid_v[w]), 64'd0);
      check_eq({tag, "_rd_busy"}, 64'(rd_busy_v[w]), 64'd0);
      check_eq({tag, "_rd_done"}, 64'(rd_done_v[w]), 64'd0);
      check_eq({tag, "_rd_data"}, rd_data_v[w], 64'd0);
      check_eq({tag, "_wr_ptr"}, 64'(wr_ptr_v[w]), 64'd0);
      check_eq({tag, "_overflow"}, 64'(overflow_v[w]), 64'd0);
    end
  endtask

  // mode 0: always ready; 1: random ready and random rd_start noise; 2: stall first beat 3 cycles.
  task automatic do_read(input int a, input int n, input int mode);
    int nb, beat, budget, stall;
    nb = (n + 1) / 2; beat = 0; budget = 400; stall = 0;
    rd_start = 1'b1; rd_addr = 6'(a); rd_len = 7'(n); rd_ready = 1'b0;
    step();
    rd_start = 1'b0;
    check_eq("rd_lat1_valid", 64'(rd_valid_v[0]), 64'd0);
    check_eq("rd_lat1_busy", 64'(rd_busy_v[0]), 64'd1);
    step();
    check_eq("rd_lat2_valid", 64'(rd_valid_v), 64'b11);
    while (beat < nb && budget > 0) begin
      budget--;
      if (rd_valid_v[0]) begin
        for (int w = 0; w < 2; w++)
          check_eq($sformatf("rd_data%0d_a%0d_b%0d", w, a, beat), rd_data_v[w], beat_val(w, a, n, beat));
        check_eq("rd_done_early", 64'(rd_done_v[0]), 64'd0);
        if (mode == 0) rd_ready = 1'b1;
        else if (mode == 2) begin
          rd_ready = (beat != 0) || (stall >= 3);
          if (beat == 0) stall++;
        end else begin
          rd_ready = 1'($urandom % 2);
          rd_start = 1'($urandom % 2); rd_addr = 6'($urandom); rd_len = 7'(1 + $urandom % 64);
        end
        step();
        rd_start = 1'b0;
        if (rd_ready) begin
          beat++;
          check_eq("rd_done_pulse", 64'(rd_done_v), (beat == nb) ? 64'b11 : 64'b00);
          if (beat == nb) begin
            check_eq("rd_valid_end", 64'(rd_valid_v), 64'd0);
            check_eq("rd_busy_end", 64'(rd_busy_v), 64'd0);
          end
        end else begin
          check_eq("rd_valid_hold", 64'(rd_valid_v), 64'b11);
        end
      end else begin
        rd_ready = 1'($urandom % 2);
        step();
      end
    end
    check_eq("rd_beats_done", 64'(beat), 64'(nb));
    rd_ready = 1'b0;
    step();
    check_eq("rd_done_once", 64'(rd_done_v), 64'd0);
    check_eq("rd_busy_after", 64'(rd_busy_v), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    do_reset();
    check_idle_outputs("reset");

    // First group after reset lands at mem[0..3].
    wr_valid = 2'b11; wr_data = {32'd4, 32'd3, 32'd2, 32'd1};
    step();
    idle_inputs();
    check_eq("grp1_wr_ptr", 64'(wr_ptr_v[0]), 64'd4);
    check_eq("grp1_full", 64'(full_v[0]), 64'd0);
    step();

    // Host preload and a burst over it.
    for (int i = 0; i < 4; i++) begin
      init_we = 1'b1; init_addr = 6'(30 + i);
      init_data = (i < 2) ? 32'(11 + i) : 32'(21 + i - 2);
      wr_valid = 2'b11;
      step();
    end
    idle_inputs();
    step();
    do_read(30, 4, 0);
    do_read(0, 4, 0);

    // Len 0 is ignored.
    rd_start = 1'b1; rd_addr = 6'd3; rd_len = 7'd0;
    step();
    rd_start = 1'b0;
    check_eq("len0_busy", 64'(rd_busy_v), 64'd0);

    // Base 62: saturating instance drops the group, wrapping instance splits it.
    wr_base_load = 1'b1; wr_base_addr = 6'd62; wr_valid = 2'b11;
    step();
    wr_base_load = 1'b0; wr_data = {32'd8, 32'd7, 32'd6, 32'd5};
    step();
    idle_inputs();
    check_eq("ovf_set", 64'(overflow_v[0]), 64'd1);
    check_eq("ovf_full", 64'(full_v[0]), 64'd1);
    check_eq("wrap_ptr", 64'(wr_ptr_v[1]), 64'd2);
    step();
    do_read(60, 6, 0);
    wr_base_load = 1'b1; wr_base_addr = 6'd0;
    step();
    idle_inputs();
    check_eq("ovf_clear", 64'(overflow_v[0]), 64'd0);

    // Odd length with a stalled first beat.
    do_read(30, 3, 2);

    // Randomised write traffic, then random bursts over the result.
    for (int c = 0; c < 400; c++) begin
      wr_valid     = ($urandom % 4 == 0) ? 2'($urandom) : 2'b11;
      wr_data      = {$urandom, $urandom, $urandom, $urandom};
      init_we      = ($urandom % 8 == 0);
      init_addr    = 6'($urandom);
      init_data    = $urandom;
      wr_base_load = ($urandom % 16 == 0);
      wr_base_addr = 6'($urandom);
      step();
    end
    idle_inputs();
    step();
    for (int r = 0; r < 8; r++) do_read(int'($urandom % 64), int'(1 + $urandom % 64), 1);
    do_read(0, 64, 0);

    // Reset in the middle of a burst.
    rd_start = 1'b1; rd_addr = 6'd5; rd_len = 7'd8;
    step();
    rd_start = 1'b0;
    step();
    check_eq("mid_valid", 64'(rd_valid_v), 64'b11);
    #1 reset = 1'b1;
    model_clear();
    #1;
    check_idle_outputs("midrst");
    @(posedge clk);
    #1;
    check_eq("midrst_done", 64'(rd_done_v), 64'd0);
    reset = 1'b0;
    step();
    check_eq("midrst_done2", 64'(rd_done_v), 64'd0);
    do_read(0, 64, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
